cursor_ctrl: RTL and testbench

- Upstream input stage for the battleship board logic.
- Conditions the five raw board push-buttons: 2-flop synchronisation, then per-button debounce.
- Turns up/down/left/right into a saturating 10×10 cursor position (`sprite_row`, `sprite_col`), with hold-to-auto-repeat.
- Passes a debounced fire level (`btn_c_clean`) to the board-state block. That block does its own rising-edge detection and bomb placement.

---
 rtl/cursor_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cursor_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_ctrl.sv
// Battleship input stage: synchronise and debounce the five push-buttons,
// then drive a saturating 10x10 cursor with hold-to-auto-repeat.

module cursor_ctrl_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // mismatch has persisted DB_CYCLES edges: accept it
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

module cursor_ctrl_repeat #(
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 15000000
) (
    input  logic clk,
    input  logic reset,
    input  logic stable,
    output logic step
);

    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HMAX + 1);
    localparam logic [HW-1:0] H_DELAY  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] H_PERIOD = HW'(REPEAT_PERIOD);
    localparam logic [HW-1:0] H_ONE    = HW'(1);

    logic          stable_q;
    logic          rep;
    logic [HW-1:0] hold;
    logic [HW-1:0] target;
    logic          press;
    logic          rep_hit;

    // first repeat waits the long delay, later ones the short period
    assign target  = rep ? H_PERIOD : H_DELAY;
    assign press   = stable & ~stable_q;
    assign rep_hit = stable & (hold == target);
    assign step    = press | rep_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= 1'b0;
            rep      <= 1'b0;
            hold     <= '0;
        end else begin
            stable_q <= stable;
            if (!stable) begin
                rep  <= 1'b0;
                hold <= '0;
            end else if (rep_hit) begin
                rep  <= 1'b1;
                hold <= H_ONE;
            end else begin
                hold <= hold + H_ONE;
            end
        end
    end

endmodule

module cursor_ctrl #(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 15000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_c,
    input  logic       lock,
    output logic [3:0] sprite_row,
    output logic [3:0] sprite_col,
    output logic       btn_c_clean,
    output logic       cursor_moved
);

    localparam logic [3:0] POS_LAST = 4'd9;

    logic [4:0] raw;
    logic [4:0] stable;
    logic [3:0] step;
    logic       up;
    logic       dn;
    logic       lf;
    logic       rt;
    logic [3:0] row_n;
    logic [3:0] col_n;

    // bit order: u, d, l, r, c
    assign raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

    for (genvar i = 0; i < 5; i++) begin : g_db
        cursor_ctrl_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .stable(stable[i])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_rep
        cursor_ctrl_repeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_rep (
            .clk   (clk),
            .reset (reset),
            .stable(stable[i]),
            .step  (step[i])
        );
    end

    assign up = step[0] & ~lock;
    assign dn = step[1] & ~lock;
    assign lf = step[2] & ~lock;
    assign rt = step[3] & ~lock;

    assign btn_c_clean = stable[4];

    always_comb begin
        row_n = sprite_row;
        col_n = sprite_col;
        if (up && !dn && sprite_row != 4'd0) begin
            row_n = sprite_row - 4'd1;
        end else if (dn && !up && sprite_row != POS_LAST) begin
            row_n = sprite_row + 4'd1;
        end
        if (lf && !rt && sprite_col != 4'd0) begin
            col_n = sprite_col - 4'd1;
        end else if (rt && !lf && sprite_col != POS_LAST) begin
            col_n = sprite_col + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sprite_row   <= 4'd0;
            sprite_col   <= 4'd0;
            cursor_moved <= 1'b0;
        end else begin
            sprite_row   <= row_n;
            sprite_col   <= col_n;
            cursor_moved <= (row_n != sprite_row) || (col_n != sprite_col);
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl: expected moves and fire-level edges
// are queued at stimulus time and matched by a negedge monitor.

module tb_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_u, btn_d, btn_l, btn_r, btn_c, lock;
    logic [3:0] sprite_row, sprite_col;
    logic       btn_c_clean, cursor_moved;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        int         cyc;
    } mv_t;

    typedef struct {
        logic lvl;
        int   cyc;
    } cl_t;

    mv_t mq[$];
    cl_t cq[$];
    mv_t me;
    cl_t ce;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic clean_q = 1'b0;

    cursor_ctrl #(
        .DB_CYCLES    (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_u       (btn_u),
        .btn_d       (btn_d),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .btn_c       (btn_c),
        .lock        (lock),
        .sprite_row  (sprite_row),
        .sprite_col  (sprite_col),
        .btn_c_clean (btn_c_clean),
        .cursor_moved(cursor_moved)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every move pulse and fire-level edge must match the queue head
    always @(negedge clk) begin
        if (reset) begin
            if (cursor_moved) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL move_unexpected got=(%0d,%0d)@%0d required=none",
                             sprite_row, sprite_col, cyc);
                end else begin
                    me = mq.pop_front();
                    if (sprite_row !== me.row || sprite_col !== me.col ||
                        cyc != me.cyc) begin
                        errors++;
                        $display("FAIL move got=(%0d,%0d)@%0d required=(%0d,%0d)@%0d",
                                 sprite_row, sprite_col, cyc,
                                 me.row, me.col, me.cyc);
                    end
                end
            end
            if (btn_c_clean !== clean_q) begin
                checks++;
                if (cq.size() == 0) begin
                    errors++;
                    $display("FAIL fire_unexpected got=%0b@%0d required=none",
                             btn_c_clean, cyc);
                end else begin
                    ce = cq.pop_front();
                    if (btn_c_clean !== ce.lvl || cyc != ce.cyc) begin
                        errors++;
                        $display("FAIL fire got=%0b@%0d required=%0b@%0d",
                                 btn_c_clean, cyc, ce.lvl, ce.cyc);
                    end
                end
            end
        end
        clean_q = btn_c_clean;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic chk_pos(input string name, input logic [3:0] r,
                           input logic [3:0] c);
        chk({name, "_row"}, 32'(sprite_row), 32'(r));
        chk({name, "_col"}, 32'(sprite_col), 32'(c));
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_row"}, 32'(sprite_row), 0);
        chk({name, "_col"}, 32'(sprite_col), 0);
        chk({name, "_fire"}, 32'(btn_c_clean), 0);
        chk({name, "_moved"}, 32'(cursor_moved), 0);
    endtask

    task automatic set_dirs(input logic [3:0] d);
        {btn_u, btn_d, btn_l, btn_r} = d;
    endtask

    // short press: 6 high samples, then low long enough to release fully
    task automatic tap(input logic [3:0] d, input bit mv,
                       input logic [3:0] er, input logic [3:0] ec);
        int c;
        @(negedge clk);
        c = cyc;
        if (mv) mq.push_back('{er, ec, c + 7});
        set_dirs(d);
        repeat (6) @(negedge clk);
        set_dirs(4'b0000);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int c;
        reset = 1'b0;
        lock  = 1'b0;
        btn_c = 1'b0;
        set_dirs(4'b0000);
        repeat (3) @(negedge clk);
        chk_reset("reset_init");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // reach (5,7): five diagonal taps then two right taps
        for (int i = 0; i < 5; i++)
            tap(4'b0101, 1'b1, 4'(i + 1), 4'(i + 1));
        tap(4'b0001, 1'b1, 4'd5, 4'd6);
        tap(4'b0001, 1'b1, 4'd5, 4'd7);
        chk_pos("pos_5_7", 4'd5, 4'd7);

        // reset mid-operation with right held
        @(negedge clk);
        btn_r = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset("reset_mid");
        mq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        c = cyc;
        mq.push_back('{4'd0, 4'd1, c + 7});
        repeat (9) @(negedge clk);
        btn_r = 1'b0;
        repeat (10) @(negedge clk);
        chk_pos("after_reset", 4'd0, 4'd1);

        // bounce on down, then steady high
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            btn_d = 1'b1;
            repeat (2) @(negedge clk);
            btn_d = 1'b0;
            repeat (2) @(negedge clk);
        end
        btn_d = 1'b1;
        c = cyc;
        mq.push_back('{4'd1, 4'd1, c + 7});
        repeat (10) @(negedge clk);
        btn_d = 1'b0;
        repeat (10) @(negedge clk);
        chk_pos("bounce", 4'd1, 4'd1);

        // clamp at (0,9)
        tap(4'b1000, 1'b1, 4'd0, 4'd1);
        for (int i = 1; i < 9; i++)
            tap(4'b0001, 1'b1, 4'd0, 4'(i + 1));
        tap(4'b1000, 1'b0, 4'd0, 4'd0);
        tap(4'b0001, 1'b0, 4'd0, 4'd0);
        chk_pos("clamp", 4'd0, 4'd9);

        // auto-repeat from (0,0)
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_pos("home", 4'd0, 4'd0);
        btn_r = 1'b1;
        c = cyc;
        mq.push_back('{4'd0, 4'd1, c + 7});
        mq.push_back('{4'd0, 4'd2, c + 27});
        mq.push_back('{4'd0, 4'd3, c + 35});
        mq.push_back('{4'd0, 4'd4, c + 43});
        mq.push_back('{4'd0, 4'd5, c + 51});
        repeat (45) @(negedge clk);
        btn_r = 1'b0;
        repeat (15) @(negedge clk);
        chk_pos("repeat", 4'd0, 4'd5);
        chk("repeat_missing", 32'(mq.size()), 0);

        // simultaneous events
        for (int i = 0; i < 4; i++)
            tap(4'b0100, 1'b1, 4'(i + 1), 4'd5);
        tap(4'b1100, 1'b0, 4'd0, 4'd0);
        chk_pos("up_down", 4'd4, 4'd5);
        tap(4'b0010, 1'b1, 4'd4, 4'd4);
        tap(4'b0110, 1'b1, 4'd5, 4'd3);
        chk_pos("diag", 4'd5, 4'd3);

        // lock freezes position
        @(negedge clk);
        lock = 1'b1;
        tap(4'b0001, 1'b0, 4'd0, 4'd0);
        lock = 1'b0;
        chk_pos("lock", 4'd5, 4'd3);

        // short fire glitch is filtered
        @(negedge clk);
        btn_c = 1'b1;
        repeat (3) @(negedge clk);
        btn_c = 1'b0;
        repeat (10) @(negedge clk);
        chk("fire_short", 32'(btn_c_clean), 0);

        // long fire press: rise and fall timing
        btn_c = 1'b1;
        c = cyc;
        cq.push_back('{1'b1, c + 6});
        cq.push_back('{1'b0, c + 16});
        repeat (10) @(negedge clk);
        btn_c = 1'b0;
        repeat (12) @(negedge clk);
        chk("fire_level", 32'(btn_c_clean), 0);

        chk("moves_missing", 32'(mq.size()), 0);
        chk("fire_missing", 32'(cq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
